// File: rtl/sha256_pkg.sv
// SHA-256 padder shared types: FSM states, block geometry constants, block-count helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PAD,
    HOLD,
    DONE
  } state_t;

  localparam int          BLOCK_BYTES     = 64;
  localparam int          LENFIELD_OFFSET = 56;
  localparam logic [7:0]  PAD_BYTE        = 8'h80;

  // Number of 512-bit blocks for a message of len bytes: data + 0x80 + 8-byte length.
  function automatic int unsigned num_blocks(input int unsigned len);
    return ((len + 32'd8) / BLOCK_BYTES) + 32'd1;
  endfunction

endpackage

// File: rtl/sha256_block_padder_if.sv
// Padded-block stream from the padder to the compression datapath.
// Latency: n/a (wires only).
// Backpressure: blk_data/blk_last/blk_index hold while blk_valid && !blk_ready.
//   master: drives blk_data, blk_valid, blk_last, blk_index; samples blk_ready
//   slave : the reverse
interface sha256_block_padder_if #(
  parameter int BLK_W = 3
);
  logic [511:0]     blk_data;
  logic             blk_valid;
  logic             blk_ready;
  logic             blk_last;
  logic [BLK_W-1:0] blk_index;

  modport master (
    output blk_data, blk_valid, blk_last, blk_index,
    input  blk_ready
  );

  modport slave (
    input  blk_data, blk_valid, blk_last, blk_index,
    output blk_ready
  );
endinterface

// File: rtl/sha256_pad_byte_sel.sv
// Padding rule for one byte: message byte, 0x80 terminator, length-field byte or zero.
// Latency: combinational.
// Backpressure: none.
//   g        : global byte number, j: byte position in the current block
//   len      : message length in bytes, last: current block is the final one
//   msg_byte : data from the message SRAM, byte_out: value to store at position j
module sha256_pad_byte_sel
  import sha256_pkg::*;
#(
  parameter int G_W   = 9,
  parameter int LEN_W = 9
) (
  input  logic [G_W-1:0]   g,
  input  logic [5:0]       j,
  input  logic [LEN_W-1:0] len,
  input  logic             last,
  input  logic [7:0]       msg_byte,
  output logic [7:0]       byte_out
);

  localparam int CW = (G_W > LEN_W) ? G_W : LEN_W;

  logic [CW-1:0] g_c;
  logic [CW-1:0] len_c;
  logic [63:0]   len_bits;

  assign g_c      = CW'(g);
  assign len_c    = CW'(len);
  assign len_bits = 64'({len, 3'b000});

  always_comb begin
    byte_out = 8'h00;
    if (g_c < len_c) begin
      byte_out = msg_byte;
    end else if (g_c == len_c) begin
      byte_out = PAD_BYTE;
    end else if (last && (j >= 6'(LENFIELD_OFFSET))) begin
      // Byte 56 is the most significant length byte (big-endian).
      byte_out = len_bits[{~j[2:0], 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/sha256_block_padder.sv
// Multi-block SHA-256 padder: reads the message SRAM and emits FIPS 180-4 padded 512-bit blocks.
// Latency: go edge to blk_valid = 58 cycles for any L<56; 65 cycles per fully fetched 64-byte block.
// Backpressure: a finished block is held in HOLD (no reads, data stable) until blk_valid && blk_ready.
//   clk/reset             : clock, synchronous active-high reset
//   xxx__dut__go/msg_length : start pulse and byte length (clamped to MAX_MESSAGE_LENGTH)
//   dut__msg__*/msg__dut__data : 1-cycle-latency byte read port
//   blk                   : padded block stream (master)
//   busy/done             : busy from go to done; done pulses once after the last block is taken
module sha256_block_padder
  import sha256_pkg::*;
#(
  parameter int MAX_MESSAGE_LENGTH = 247,
  parameter int ADDR_W             = $clog2(MAX_MESSAGE_LENGTH),
  parameter int LEN_W              = $clog2(MAX_MESSAGE_LENGTH) + 1,
  parameter int BLK_W              = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  xxx__dut__go,
  input  logic [LEN_W-1:0]      xxx__dut__msg_length,
  output logic [ADDR_W-1:0]     dut__msg__address,
  output logic                  dut__msg__enable,
  output logic                  dut__msg__write,
  input  logic [7:0]            msg__dut__data,
  sha256_block_padder_if.master blk,
  output logic                  busy,
  output logic                  done
);

  // Global byte counter: block number in the upper bits, position j in the low 6.
  localparam int G_W = BLK_W + 6;
  localparam int CW  = (G_W > LEN_W) ? G_W : LEN_W;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [G_W-1:0]   g;
  logic [BLK_W-1:0] last_idx;
  logic             rd_pend;
  logic [5:0]       rd_slot;

  logic [5:0]       j;
  logic             in_block;
  logic             more_msg;
  logic             is_last;
  logic             rd_issue;
  logic [LEN_W-1:0] len_clamp;
  logic [7:0]       lane_byte [8];

  assign j         = g[5:0];
  assign in_block  = (g[G_W-1:6] == blk.blk_index);
  assign more_msg  = (CW'(g) < CW'(len));
  assign is_last   = (blk.blk_index == last_idx);
  assign rd_issue  = (state == FETCH) && more_msg && in_block;
  assign len_clamp = (xxx__dut__msg_length > LEN_W'(MAX_MESSAGE_LENGTH)) ?
                     LEN_W'(MAX_MESSAGE_LENGTH) : xxx__dut__msg_length;

  assign dut__msg__address = ADDR_W'(g);
  assign dut__msg__enable  = rd_issue;
  assign dut__msg__write   = 1'b0;

  // Eight consecutive byte lanes starting at g: lane 0 serves the one-byte-per-cycle
  // PAD path, all eight together write the length field in a single cycle at j==56.
  for (genvar k = 0; k < 8; k++) begin : g_lane
    sha256_pad_byte_sel #(
      .G_W   (G_W),
      .LEN_W (LEN_W)
    ) u_sel (
      .g        (g + G_W'(k)),
      .j        (j + 6'(k)),
      .len      (len),
      .last     (is_last),
      .msg_byte (msg__dut__data),
      .byte_out (lane_byte[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      len           <= '0;
      g             <= '0;
      last_idx      <= '0;
      rd_pend       <= 1'b0;
      rd_slot       <= '0;
      blk.blk_data  <= '0;
      blk.blk_valid <= 1'b0;
      blk.blk_last  <= 1'b0;
      blk.blk_index <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      // Read data arrives one cycle after the enable; drop it into the slot it was issued for.
      rd_pend <= rd_issue;
      rd_slot <= j;
      if (rd_pend) begin
        blk.blk_data[{~rd_slot, 3'b000} +: 8] <= msg__dut__data;
      end

      case (state)
        IDLE: begin
          if (xxx__dut__go) begin
            len           <= len_clamp;
            last_idx      <= BLK_W'(num_blocks(32'(len_clamp)) - 32'd1);
            g             <= '0;
            blk.blk_index <= '0;
            busy          <= 1'b1;
            state         <= FETCH;
          end
        end

        FETCH: begin
          if (rd_issue) begin
            g <= g + 1'b1;
          end else if (in_block) begin
            // Message exhausted inside this block; the final read lands this cycle.
            state <= PAD;
          end else begin
            // Block filled entirely by reads; byte 63 lands this cycle.
            blk.blk_valid <= 1'b1;
            blk.blk_last  <= is_last;
            state         <= HOLD;
          end
        end

        PAD: begin
          if (is_last && (j == 6'(LENFIELD_OFFSET))) begin
            blk.blk_data[63:0] <= {lane_byte[0], lane_byte[1], lane_byte[2], lane_byte[3],
                                   lane_byte[4], lane_byte[5], lane_byte[6], lane_byte[7]};
            blk.blk_valid      <= 1'b1;
            blk.blk_last       <= 1'b1;
            state              <= HOLD;
          end else begin
            blk.blk_data[{~j, 3'b000} +: 8] <= lane_byte[0];
            g <= g + 1'b1;
            if (j == 6'd63) begin
              blk.blk_valid <= 1'b1;
              blk.blk_last  <= is_last;
              state         <= HOLD;
            end
          end
        end

        HOLD: begin
          if (blk.blk_valid && blk.blk_ready) begin
            blk.blk_valid <= 1'b0;
            blk.blk_last  <= 1'b0;
            if (is_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // g already points at the first byte of the next block.
              blk.blk_index <= blk.blk_index + 1'b1;
              state         <= more_msg ? FETCH : PAD;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_padder.sv
// Directed bench for sha256_block_padder with a 1-cycle-latency message SRAM model.
// Latency: n/a.
// Backpressure: bench drives blk_ready either tied high or stalled per block.
module tb_sha256_block_padder;

  localparam int LEN_W  = 9;
  localparam int ADDR_W = 8;
  localparam int BLK_W  = 3;
  localparam int TMO    = 1000;

  logic              clk = 1'b0;
  logic              reset;
  logic              go;
  logic [LEN_W-1:0]  msg_length;
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic              wr;
  logic [7:0]        rdata;
  logic              busy;
  logic              done;

  sha256_block_padder_if #(.BLK_W(BLK_W)) bif ();

  sha256_block_padder #(
    .MAX_MESSAGE_LENGTH (247),
    .ADDR_W             (ADDR_W),
    .LEN_W              (LEN_W),
    .BLK_W              (BLK_W)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .xxx__dut__go         (go),
    .xxx__dut__msg_length (msg_length),
    .dut__msg__address    (addr),
    .dut__msg__enable     (en),
    .dut__msg__write      (wr),
    .msg__dut__data       (rdata),
    .blk                  (bif),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) if (en) rdata <= mem[addr];

  int errors = 0;
  int checks = 0;
  logic ready_tie = 1'b0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor, sampled mid-cycle after the bench has driven its inputs.
  int          rd_cnt = 0, done_cnt = 0, unstable = 0, hold_rd = 0;
  logic [7:0]  rd_log [$];
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [511:0] pd = '0;
  logic [2:0]  pi = '0;
  always @(negedge clk) begin
    #1;
    if (en) begin rd_cnt++; rd_log.push_back(addr); end
    if (done) done_cnt++;
    if (bif.blk_valid && en) hold_rd++;
    if (pv && !pr && !reset &&
        (bif.blk_valid !== 1'b1 || bif.blk_data !== pd || bif.blk_last !== pl || bif.blk_index !== pi))
      unstable++;
    pv = bif.blk_valid; pr = bif.blk_ready; pd = bif.blk_data;
    pl = bif.blk_last;  pi = bif.blk_index;
  end

  // Expected block for messages whose byte g holds the value g.
  function automatic logic [511:0] ref_block(input int L, input int b, input bit last);
    logic [511:0] r;
    int gb;
    r = '0;
    for (int jj = 0; jj < 64; jj++) begin
      gb = 64 * b + jj;
      if (gb < L)       r[511 - 8*jj -: 8] = 8'(gb);
      else if (gb == L) r[511 - 8*jj -: 8] = 8'h80;
    end
    if (last) r[63:0] = 64'(L * 8);
    return r;
  endfunction

  task automatic start(input int L);
    go = 1'b1;
    msg_length = LEN_W'(L);
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic get_block(input int stall, output logic [511:0] d, output logic l,
                           output logic [2:0] idx, output int lat);
    lat = 0;
    while (bif.blk_valid !== 1'b1 && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    chk("blk_timeout", (lat >= TMO), 1'b0);
    d = bif.blk_data; l = bif.blk_last; idx = bif.blk_index;
    repeat (stall) @(negedge clk);
    bif.blk_ready = 1'b1;
    @(negedge clk);
    bif.blk_ready = ready_tie;
  endtask

  logic [511:0] d;
  logic         l;
  logic [2:0]   idx;
  int           lat, b_rd, b_q, b_dn, w;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

  initial begin
    reset = 1'b1; go = 1'b0; msg_length = '0; bif.blk_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    chk("rst_valid", bif.blk_valid, 1'b0);
    chk("rst_last",  bif.blk_last,  1'b0);
    chk("rst_index", bif.blk_index, 3'd0);
    chk("rst_data",  bif.blk_data,  512'h0);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_done",  done, 1'b0);
    chk("rst_en",    en,   1'b0);
    chk("rst_write", wr,   1'b0);
    reset = 1'b0;
    @(negedge clk);

    // "abc", ready tied high (and high before any block is valid)
    ready_tie = 1'b1; bif.blk_ready = 1'b1;
    mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
    b_rd = rd_cnt; b_q = rd_log.size(); b_dn = done_cnt;
    start(3);
    chk("abc_busy", busy, 1'b1);
    get_block(0, d, l, idx, lat);
    chk("abc_data",  d,   ABC_BLK);
    chk("abc_last",  l,   1'b1);
    chk("abc_index", idx, 3'd0);
    chk("abc_lat_le70", (lat <= 70), 1'b1);
    repeat (3) @(negedge clk);
    chk("abc_done_once", done_cnt - b_dn, 1);
    chk("abc_reads", rd_cnt - b_rd, 3);
    for (int k = 0; k < 3; k++) chk("abc_addr", rd_log[b_q + k], 8'(k));
    chk("abc_idle_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) mem[i] = 8'(i);

    // L=0: single block, no reads
    b_rd = rd_cnt;
    start(0);
    get_block(0, d, l, idx, lat);
    chk("l0_data", d, {8'h80, 440'h0, 64'h0});
    chk("l0_last", l, 1'b1);
    chk("l0_reads", rd_cnt - b_rd, 0);
    repeat (2) @(negedge clk);

    // L=56: terminator in block 0, length alone in block 1
    b_rd = rd_cnt;
    start(56);
    get_block(0, d, l, idx, lat);
    chk("l56_b0_data", d, ref_block(56, 0, 1'b0));
    chk("l56_b0_last", l, 1'b0);
    get_block(0, d, l, idx, lat);
    chk("l56_b1_data",  d, {448'h0, 64'h1C0});
    chk("l56_b1_last",  l, 1'b1);
    chk("l56_b1_index", idx, 3'd1);
    chk("l56_reads", rd_cnt - b_rd, 56);
    repeat (2) @(negedge clk);

    // L=64: full first block (65-cycle latency), terminator opens block 1
    start(64);
    get_block(0, d, l, idx, lat);
    chk("l64_b0_lat",  lat, 65);
    chk("l64_b0_data", d, ref_block(64, 0, 1'b0));
    get_block(0, d, l, idx, lat);
    chk("l64_b1_data", d, {8'h80, 440'h0, 64'h200});
    chk("l64_b1_last", l, 1'b1);
    repeat (2) @(negedge clk);

    // L=100 with ready 1-in-3, go while busy and go in the DONE cycle
    ready_tie = 1'b0; bif.blk_ready = 1'b0;
    b_rd = rd_cnt; b_dn = done_cnt;
    start(100);
    repeat (5) @(negedge clk);
    start(3);
    get_block(2, d, l, idx, lat);
    chk("l100_b0_data",  d, ref_block(100, 0, 1'b0));
    chk("l100_b0_last",  l, 1'b0);
    chk("l100_b0_index", idx, 3'd0);
    w = 0;
    while (bif.blk_valid !== 1'b1 && w < TMO) begin @(negedge clk); w++; end
    repeat (4) @(negedge clk);
    chk("l100_held_valid", bif.blk_valid, 1'b1);
    chk("l100_no_early_done", done_cnt - b_dn, 0);
    get_block(2, d, l, idx, lat);
    chk("l100_b1_data",  d, ref_block(100, 1, 1'b1));
    chk("l100_b1_last",  l, 1'b1);
    chk("l100_b1_index", idx, 3'd1);
    chk("done_cycle_done", done, 1'b1);
    chk("done_cycle_busy", busy, 1'b0);
    start(5);
    chk("go_in_done_busy", busy, 1'b0);
    repeat (70) @(negedge clk);
    chk("go_in_done_novalid", bif.blk_valid, 1'b0);
    chk("l100_reads", rd_cnt - b_rd, 100);
    chk("hold_reads", hold_rd, 0);
    chk("hold_stable", unstable, 0);
    chk("l100_done_once", done_cnt - b_dn, 1);

    // Second message after done: L=55, still one block
    ready_tie = 1'b1; bif.blk_ready = 1'b1;
    start(55);
    get_block(0, d, l, idx, lat);
    chk("l55_data", d, ref_block(55, 0, 1'b1));
    chk("l55_last", l, 1'b1);
    repeat (2) @(negedge clk);

    // Oversized length clamps to 247: four blocks
    start(300);
    for (int b = 0; b < 4; b++) begin
      get_block(0, d, l, idx, lat);
      chk("clamp_index", idx, 3'(b));
      chk("clamp_last",  l, (b == 3));
    end
    chk("clamp_b3_data", d, ref_block(247, 3, 1'b1));
    repeat (2) @(negedge clk);

    // Reset during FETCH of block 1 (L=200)
    start(200);
    get_block(0, d, l, idx, lat);
    repeat (10) @(negedge clk);
    chk("mid_fetch_en", en, 1'b1);
    b_dn = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("mr_valid", bif.blk_valid, 1'b0);
    chk("mr_busy",  busy, 1'b0);
    chk("mr_done",  done, 1'b0);
    chk("mr_index", bif.blk_index, 3'd0);
    chk("mr_data",  bif.blk_data, 512'h0);
    chk("mr_en",    en, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("mr_no_done", done_cnt - b_dn, 0);
    mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
    start(3);
    get_block(0, d, l, idx, lat);
    chk("mr_abc_data", d, ABC_BLK);
    chk("mr_abc_last", l, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
